// File: rtl/scb_cdb_clear_arbiter.sv
// Collects ALU/MEM regwrite-completion tokens into per-source FIFOs and round-robins them onto the shared scoreboard CDB clear port.
// Optional feature: define SCB_CLEAR_BYPASS_EN to let a winning token into an empty FIFO skip straight to the output register.
module scb_cdb_clear_arbiter #(
  parameter int unsigned NUM_WARPS       = 8,
  parameter int unsigned NUM_ENTRIES     = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned LOG_NUM_WARPS   = $clog2(NUM_WARPS),
  parameter int unsigned LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [LOG_NUM_WARPS-1:0]   alu_WarpID,
  input  logic [LOG_NUM_ENTRIES-1:0] alu_ScbID,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [LOG_NUM_WARPS-1:0]   mem_WarpID,
  input  logic [LOG_NUM_ENTRIES-1:0] mem_ScbID,
  output logic [LOG_NUM_ENTRIES-1:0] ScbID_CDB_Scb,
  output logic [NUM_WARPS-1:0]       ScbID_valid_CDB_Scb,
  output logic                       busy
);

  localparam int unsigned NSRC  = 2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TOK_W = LOG_NUM_WARPS + LOG_NUM_ENTRIES;

  // Source 0 is ALU, source 1 is MEM; a token is {WarpID, ScbID}.
  logic [TOK_W-1:0]           fifo_q   [NSRC][FIFO_DEPTH];
  logic [TOK_W-1:0]           fifo_d   [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q [NSRC];
  logic [PTR_W-1:0]           wr_ptr_d [NSRC];
  logic [PTR_W-1:0]           rd_ptr_q [NSRC];
  logic [PTR_W-1:0]           rd_ptr_d [NSRC];
  logic [CNT_W-1:0]           cnt_q    [NSRC];
  logic [CNT_W-1:0]           cnt_d    [NSRC];
  logic                       rr_q, rr_d;
  logic [LOG_NUM_ENTRIES-1:0] scb_id_q, scb_id_d;
  logic [NUM_WARPS-1:0]       clr_vld_q, clr_vld_d;

  logic [TOK_W-1:0] tok_in_c [NSRC];
  logic [TOK_W-1:0] head_c   [NSRC];
  logic [TOK_W-1:0] win_tok_c;
  logic [NSRC-1:0]  in_vld_c, ready_c, empty_c, push_c, req_c, gnt_c, byp_c, pop_c, wr_c;

  assign tok_in_c[0] = {alu_WarpID, alu_ScbID};
  assign tok_in_c[1] = {mem_WarpID, mem_ScbID};
  assign in_vld_c    = {mem_valid, alu_valid};

  // FIFO bookkeeping, round-robin grant and output register next-state.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    scb_id_d  = scb_id_q;
    clr_vld_d = '0;
    ready_c   = '0;
    empty_c   = '0;
    push_c    = '0;
    req_c     = '0;
    gnt_c     = '0;
    byp_c     = '0;
    pop_c     = '0;
    wr_c      = '0;
    win_tok_c = '0;
    head_c[0] = '0;
    head_c[1] = '0;

    for (int s = 0; s < NSRC; s++) begin
      ready_c[s] = (cnt_q[s] != CNT_W'(FIFO_DEPTH));
      empty_c[s] = (cnt_q[s] == '0);
      push_c[s]  = in_vld_c[s] & ready_c[s];
`ifdef SCB_CLEAR_BYPASS_EN
      req_c[s]   = ~empty_c[s] | push_c[s];
      head_c[s]  = empty_c[s] ? tok_in_c[s] : fifo_q[s][rd_ptr_q[s]];
`else
      req_c[s]   = ~empty_c[s];
      head_c[s]  = fifo_q[s][rd_ptr_q[s]];
`endif
    end

    // rr_q == 0 favours ALU when both sources request.
    if (&req_c) gnt_c = rr_q ? 2'b10 : 2'b01;
    else        gnt_c = req_c;

    for (int s = 0; s < NSRC; s++) begin
      byp_c[s] = gnt_c[s] & empty_c[s];
      pop_c[s] = gnt_c[s] & ~empty_c[s];
      wr_c[s]  = push_c[s] & ~byp_c[s];
      if (wr_c[s]) begin
        fifo_d[s][wr_ptr_q[s]] = tok_in_c[s];
        wr_ptr_d[s]            = wr_ptr_q[s] + PTR_W'(1);
      end
      if (pop_c[s]) rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      cnt_d[s] = cnt_q[s] + CNT_W'(wr_c[s]) - CNT_W'(pop_c[s]);
    end

    win_tok_c = gnt_c[1] ? head_c[1] : head_c[0];
    if (|gnt_c) begin
      rr_d      = gnt_c[0];
      scb_id_d  = win_tok_c[LOG_NUM_ENTRIES-1:0];
      clr_vld_d = NUM_WARPS'(1) << win_tok_c[TOK_W-1:LOG_NUM_ENTRIES];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[s][i] <= '0;
      end
      rr_q      <= 1'b0;
      scb_id_q  <= '0;
      clr_vld_q <= '0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      scb_id_q  <= scb_id_d;
      clr_vld_q <= clr_vld_d;
    end
  end

  assign alu_ready           = ready_c[0];
  assign mem_ready           = ready_c[1];
  assign ScbID_CDB_Scb       = scb_id_q;
  assign ScbID_valid_CDB_Scb = clr_vld_q;
  assign busy                = ~empty_c[0] | ~empty_c[1] | (|clr_vld_q);

endmodule

// File: tb/tb_scb_cdb_clear_arbiter.sv
// Directed bench for scb_cdb_clear_arbiter (default build: no bypass, 2-cycle latency).
module tb_scb_cdb_clear_arbiter;

  localparam int unsigned NW = 8;
  localparam int unsigned NE = 4;

  logic          clk;
  logic          rst;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [2:0]    alu_WarpID, mem_WarpID;
  logic [1:0]    alu_ScbID, mem_ScbID;
  logic [1:0]    ScbID_CDB_Scb;
  logic [NW-1:0] ScbID_valid_CDB_Scb;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  scb_cdb_clear_arbiter #(.NUM_WARPS(NW), .NUM_ENTRIES(NE), .FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_valid           (alu_valid),
    .alu_ready           (alu_ready),
    .alu_WarpID          (alu_WarpID),
    .alu_ScbID           (alu_ScbID),
    .mem_valid           (mem_valid),
    .mem_ready           (mem_ready),
    .mem_WarpID          (mem_WarpID),
    .mem_ScbID           (mem_ScbID),
    .ScbID_CDB_Scb       (ScbID_CDB_Scb),
    .ScbID_valid_CDB_Scb (ScbID_valid_CDB_Scb),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_clear(input string tag, input int warp, input int scb);
    logic [NW-1:0] oh;
    oh = NW'(1) << warp;
    chk({tag, "_vld"}, 32'(ScbID_valid_CDB_Scb), 32'(oh));
    chk({tag, "_scb"}, 32'(ScbID_CDB_Scb), 32'(scb));
  endtask

  initial begin
    int ai, mi, k;
    logic pa, pm;
    int exp_w [6];
    int exp_s [6];
    exp_w = '{0, 5, 1, 6, 2, 7};
    exp_s = '{0, 3, 1, 2, 2, 1};

    // Reset held with an ALU token offered.
    rst = 1'b0;
    alu_valid = 1'b1; alu_WarpID = 3'd3; alu_ScbID = 2'd2;
    mem_valid = 1'b0; mem_WarpID = '0;   mem_ScbID = '0;
    tick(); tick();
    chk("rst_vld",   32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("rst_scb",   32'(ScbID_CDB_Scb),       32'h0);
    chk("rst_busy",  32'(busy),                32'h0);
    chk("rst_aready", 32'(alu_ready),          32'h1);
    chk("rst_mready", 32'(mem_ready),          32'h1);

    // Release: token (3,2) pushed at the next edge, clear one edge later.
    rst = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("lat_t_vld",  32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("lat_t_busy", 32'(busy),                32'h1);
    tick();
    chk("lat_t1_vld", 32'(ScbID_valid_CDB_Scb), 32'h08);
    chk("lat_t1_scb", 32'(ScbID_CDB_Scb),       32'h2);
    tick();
    chk("lat_t2_vld",  32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("lat_t2_scb",  32'(ScbID_CDB_Scb),       32'h2);
    chk("lat_t2_busy", 32'(busy),                32'h0);

    // Contention: reset so the RR pointer favours ALU, then load 3 tokens on each side.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        alu_valid = 1'b1; alu_WarpID = 3'(c);     alu_ScbID = 2'(c);
        mem_valid = 1'b1; mem_WarpID = 3'(5 + c); mem_ScbID = 2'(3 - c);
      end else begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
      end
      tick();
      if (c >= 1) chk_clear($sformatf("rr%0d", c - 1), exp_w[c - 1], exp_s[c - 1]);
    end
    tick();
    chk("rr_done_vld",  32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("rr_done_busy", 32'(busy),                32'h0);

    // Full: both producers stream continuously; MEM fills while sharing the port.
    ai = 0;
    mi = 0;
    for (int n = 0; n < 13; n++) begin
      alu_valid = 1'b1; alu_WarpID = 3'(ai % 4);     alu_ScbID = 2'(3 - (ai % 4));
      mem_valid = 1'b1; mem_WarpID = 3'(4 + mi % 4); mem_ScbID = 2'(mi % 4);
      pa = alu_ready;
      pm = mem_ready;
      tick();
      if (pa) ai++;
      if (pm) mi++;
      if (n >= 1) begin
        if (n % 2 == 1) begin
          k = (n - 1) / 2;
          chk_clear($sformatf("full_alu%0d", k), k % 4, 3 - (k % 4));
        end else begin
          k = (n - 2) / 2;
          chk_clear($sformatf("full_mem%0d", k), 4 + k % 4, k % 4);
        end
      end
      if (n == 4) chk("full_mready_e4", 32'(mem_ready), 32'h1);
      if (n == 5) chk("full_mready_e5", 32'(mem_ready), 32'h0);
      if (n == 6) begin
        chk("full_mready_e6", 32'(mem_ready), 32'h1);
        chk("full_aready_e6", 32'(alu_ready), 32'h0);
      end
      if (n == 7) chk("full_mready_e7", 32'(mem_ready), 32'h0);
    end
    chk("full_busy", 32'(busy), 32'h1);

    // Reset with tokens still queued: nothing may come out afterwards.
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_vld",  32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("mid_rst_busy", 32'(busy),                32'h0);
    tick();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("post_rst_vld%0d", n),  32'(ScbID_valid_CDB_Scb), 32'h0);
      chk($sformatf("post_rst_busy%0d", n), 32'(busy),                32'h0);
    end
    chk("post_rst_mready", 32'(mem_ready), 32'h1);

    // Wrap-around: 10 back-to-back MEM tokens, no ALU traffic.
    for (int n = 0; n < 11; n++) begin
      if (n < 10) begin
        mem_valid = 1'b1; mem_WarpID = 3'((n * 3) % 8); mem_ScbID = 2'(n % 4);
      end else begin
        mem_valid = 1'b0;
      end
      tick();
      if (n >= 1) begin
        chk_clear($sformatf("wrap%0d", n - 1), ((n - 1) * 3) % 8, (n - 1) % 4);
        chk($sformatf("wrap_busy%0d", n - 1), 32'(busy), 32'h1);
      end
    end
    tick();
    chk("wrap_end_vld",  32'(ScbID_valid_CDB_Scb), 32'h0);
    chk("wrap_end_busy", 32'(busy),                32'h0);
    chk("wrap_end_scb",  32'(ScbID_CDB_Scb),       32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
